// File: rtl/score_ctrl.sv
// score_ctrl: sequencing controller for the on-screen score datapath.
// It advances the score on frame ticks, credits gift bonuses, runs the
// milestone blink and blanks the digits.
// Optional feature: define SCORE_HISCORE_EN to track the session high score.
module score_ctrl #(
  parameter int unsigned TICK_DIV   = 10,
  parameter int unsigned SCORE_MAX  = 99999,
  parameter int unsigned GIFT_BONUS = 100,
  parameter int unsigned MILESTONE  = 100,
  parameter int unsigned BLINK_LEN  = 200,
  parameter int unsigned BLINK_HALF = 25
) (
  input  logic        frame_Clk,
  input  logic        Reset,
  input  logic [1:0]  Game_State,
  input  logic        Dead,
  input  logic        gift_req,
  output logic        gift_ack,
  output logic [16:0] score,
  output logic        blink,
  output logic        hide,
  output logic [16:0] hiscore,
  output logic        run
);

  localparam int unsigned BLINK_W   = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
  localparam int unsigned BLINK_PER = 2 * BLINK_HALF;

  localparam logic [1:0] GS_TITLE = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_OVER  = 2'b10;
  localparam logic [1:0] GS_PAUSE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           tick_cnt, tick_cnt_nxt;
  logic [16:0]          score_nxt;
  logic                 pending, pending_nxt;
  logic                 armed, armed_nxt;
  logic                 gift_ack_nxt;
  logic                 blink_nxt;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_nxt;
  logic                 run_nxt;
  logic [17:0]          sum, sum_wrap;
  logic                 wrapped, milestone, stay_run, tick, accept;

  // State register
  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; Dead outranks every Game_State request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (Game_State == GS_PLAY && !Dead) state_nxt = RUN;
      RUN: begin
        if (Dead || Game_State == GS_OVER) state_nxt = HALT;
        else if (Game_State == GS_PAUSE)   state_nxt = PAUSE;
        else if (Game_State == GS_TITLE)   state_nxt = IDLE;
      end
      PAUSE: begin
        if (Dead || Game_State == GS_OVER) state_nxt = HALT;
        else if (Game_State == GS_PLAY)    state_nxt = RUN;
        else if (Game_State == GS_TITLE)   state_nxt = IDLE;
      end
      HALT:  if (Game_State == GS_TITLE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Score arithmetic: tick sum with wrap and milestone detection
  always_comb begin
    stay_run  = (state == RUN) && (state_nxt == RUN);
    tick      = stay_run && (tick_cnt == 8'(TICK_DIV));
    accept    = stay_run && gift_req && !pending && armed;
    sum       = 18'(score) + 18'd1 + (pending ? 18'(GIFT_BONUS) : 18'd0);
    wrapped   = sum > 18'(SCORE_MAX);
    sum_wrap  = wrapped ? (sum - 18'(SCORE_MAX + 1)) : sum;
    milestone = wrapped ||
                ((sum_wrap != 18'd0) &&
                 ((32'(sum_wrap) / MILESTONE) != (32'(score) / MILESTONE)));
  end

  // Datapath next values: tick, gift handshake, blink timer
  always_comb begin
    tick_cnt_nxt  = tick_cnt;
    score_nxt     = score;
    pending_nxt   = pending;
    armed_nxt     = armed;
    gift_ack_nxt  = 1'b0;
    blink_nxt     = blink;
    blink_cnt_nxt = blink_cnt;
    run_nxt       = (state_nxt == RUN);

    if (!gift_req) armed_nxt = 1'b1;
    if (accept)    armed_nxt = 1'b0;

    if (blink) begin
      if (blink_cnt == BLINK_W'(BLINK_LEN - 1)) begin
        blink_nxt     = 1'b0;
        blink_cnt_nxt = '0;
      end else begin
        blink_cnt_nxt = blink_cnt + BLINK_W'(1);
      end
    end

    if (state == IDLE && state_nxt == RUN) begin
      score_nxt     = '0;
      tick_cnt_nxt  = 8'd1;
      pending_nxt   = 1'b0;
      blink_nxt     = 1'b0;
      blink_cnt_nxt = '0;
    end

    if (stay_run) begin
      if (tick) begin
        tick_cnt_nxt = 8'd1;
        score_nxt    = 17'(sum_wrap);
        pending_nxt  = 1'b0;
        if (milestone) begin
          blink_nxt     = 1'b1;
          blink_cnt_nxt = '0;
        end
      end else begin
        tick_cnt_nxt = tick_cnt + 8'd1;
      end
    end

    // A gift accepted on a tick edge is credited on the following tick
    if (accept) begin
      pending_nxt  = 1'b1;
      gift_ack_nxt = 1'b1;
    end

    if (state_nxt == HALT && state != HALT) pending_nxt = 1'b0;
  end

  // Datapath registers
  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt  <= 8'd1;
      score     <= '0;
      pending   <= 1'b0;
      armed     <= 1'b1;
      gift_ack  <= 1'b0;
      blink     <= 1'b0;
      blink_cnt <= '0;
      run       <= 1'b0;
    end else begin
      tick_cnt  <= tick_cnt_nxt;
      score     <= score_nxt;
      pending   <= pending_nxt;
      armed     <= armed_nxt;
      gift_ack  <= gift_ack_nxt;
      blink     <= blink_nxt;
      blink_cnt <= blink_cnt_nxt;
      run       <= run_nxt;
    end
  end

  // Digits blank during the off half of each blink period
  assign hide = blink & ((32'(blink_cnt) % BLINK_PER) >= 32'(BLINK_HALF));

`ifdef SCORE_HISCORE_EN
  // Session best: score is frozen in HALT, so the edge after entry captures it
  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset)                              hiscore <= '0;
    else if (state == HALT && score > hiscore) hiscore <= score;
  end
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed bench for score_ctrl with a frame-level reference model.
module tb_score_ctrl;

  localparam int unsigned TB_TICK   = 10;
  localparam int unsigned TB_MAX    = 999;
  localparam int unsigned TB_GIFT   = 100;
  localparam int unsigned TB_MILE   = 100;
  localparam int unsigned TB_BLEN   = 200;
  localparam int unsigned TB_BHALF  = 25;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_HALT  = 3;

  logic        frame_Clk = 1'b0;
  logic        Reset;
  logic [1:0]  Game_State;
  logic        Dead;
  logic        gift_req;
  logic        gift_ack;
  logic [16:0] score;
  logic        blink;
  logic        hide;
  logic [16:0] hiscore;
  logic        run;

  score_ctrl #(
    .TICK_DIV(TB_TICK), .SCORE_MAX(TB_MAX), .GIFT_BONUS(TB_GIFT),
    .MILESTONE(TB_MILE), .BLINK_LEN(TB_BLEN), .BLINK_HALF(TB_BHALF)
  ) dut (
    .frame_Clk(frame_Clk), .Reset(Reset), .Game_State(Game_State), .Dead(Dead),
    .gift_req(gift_req), .gift_ack(gift_ack), .score(score), .blink(blink),
    .hide(hide), .hiscore(hiscore), .run(run)
  );

  always #5 frame_Clk = ~frame_Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int acks     = 0;

  // Reference model: game mode, frames since last tick, blink age (-1 = off)
  int m_mode  = M_IDLE;
  int m_score = 0;
  int m_phase = 0;
  int m_age   = -1;
  int m_hi    = 0;
  bit m_bonus = 1'b0;
  bit m_armed = 1'b1;
  bit m_ack   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int hi_exp(input int v);
    return HI_EN ? v : 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_score = 0; m_phase = 0; m_age = -1; m_hi = 0;
    m_bonus = 1'b0; m_armed = 1'b1; m_ack = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] gs, input logic dead, input logic greq);
    int nm;
    int raw;
    int nxt;
    bit take;
    nm = m_mode;
    case (m_mode)
      M_IDLE: if (gs == 2'b01 && !dead) nm = M_RUN;
      M_RUN, M_PAUSE: begin
        if (dead || gs == 2'b10) nm = M_HALT;
        else if (gs == 2'b00)    nm = M_IDLE;
        else if (gs == 2'b11)    nm = M_PAUSE;
        else                     nm = M_RUN;
      end
      default: if (gs == 2'b00) nm = M_IDLE;
    endcase
    if (m_mode == M_HALT && m_score > m_hi) m_hi = m_score;
    m_ack = 1'b0;
    take  = 1'b0;
    if (m_age >= 0) begin
      m_age++;
      if (m_age == int'(TB_BLEN)) m_age = -1;
    end
    if (m_mode == M_IDLE && nm == M_RUN) begin
      m_score = 0; m_phase = 0; m_bonus = 1'b0; m_age = -1;
    end
    if (m_mode == M_RUN && nm == M_RUN) begin
      take = greq && !m_bonus && m_armed;
      m_phase++;
      if (m_phase == int'(TB_TICK)) begin
        raw = m_score + 1 + (m_bonus ? int'(TB_GIFT) : 0);
        nxt = raw % int'(TB_MAX + 1);
        if (raw > int'(TB_MAX) ||
            (nxt != 0 && nxt / int'(TB_MILE) != m_score / int'(TB_MILE)))
          m_age = 0;
        m_score = nxt; m_bonus = 1'b0; m_phase = 0;
      end
      if (take) begin
        m_bonus = 1'b1; m_ack = 1'b1;
      end
    end
    if (!greq)     m_armed = 1'b1;
    else if (take) m_armed = 1'b0;
    if (nm == M_HALT && m_mode != M_HALT) m_bonus = 1'b0;
    m_mode = nm;
  endtask

  // Per-frame compare of every output against the model
  always @(posedge frame_Clk) begin
    if (Reset) model_reset();
    else       model_step(Game_State, Dead, gift_req);
    #1;
    chk("score",    32'(score),    32'(m_score));
    chk("run",      32'(run),      32'(m_mode == M_RUN));
    chk("gift_ack", 32'(gift_ack), 32'(m_ack));
    chk("blink",    32'(blink),    32'(m_age >= 0));
    chk("hide",     32'(hide),     32'(m_age >= 0 && (m_age % int'(2 * TB_BHALF)) >= int'(TB_BHALF)));
    chk("hiscore",  32'(hiscore),  32'(hi_exp(m_hi)));
    if (gift_ack === 1'b1) acks++;
  end

  task automatic frames(input int n);
    repeat (n) @(negedge frame_Clk);
  endtask

  initial begin
    Reset = 1'b1; Game_State = 2'b00; Dead = 1'b0; gift_req = 1'b0;
    frames(3);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_run",   32'(run),   32'd0);
    chk("rst_ack",   32'(gift_ack), 32'd0);
    chk("rst_blink", 32'(blink), 32'd0);
    chk("rst_hide",  32'(hide),  32'd0);
    chk("rst_hi",    32'(hiscore), 32'd0);
    Reset = 1'b0;
    frames(1);

    // First tick lands TICK_DIV edges after entering RUN
    Game_State = 2'b01;
    frames(1);
    chk("enter_run", 32'(run), 32'd1);
    frames(9);
    chk("pre_tick", 32'(score), 32'd0);
    frames(1);
    chk("first_tick", 32'(score), 32'd1);
    frames(90);
    chk("score_10", 32'(score), 32'd10);

    // Held request: one ack, bonus on the next tick
    gift_req = 1'b1;
    frames(10);
    chk("gift_bonus", 32'(score), 32'd111);
    frames(20);
    chk("one_ack", 32'(acks), 32'd1);
    chk("held_score", 32'(score), 32'd113);
    gift_req = 1'b0;
    frames(1);
    gift_req = 1'b1;
    frames(1);
    gift_req = 1'b0;
    frames(8);
    chk("second_ack", 32'(acks), 32'd2);
    chk("second_bonus", 32'(score), 32'd214);
    chk("blink_restart", 32'(blink), 32'd1);
    chk("hide_restart", 32'(hide), 32'd0);

    // Pause inside the blink window
    frames(3);
    Game_State = 2'b11;
    frames(30);
    chk("pause_hide", 32'(hide), 32'd1);
    frames(20);
    chk("pause_score", 32'(score), 32'd214);
    chk("pause_run", 32'(run), 32'd0);
    Game_State = 2'b01;
    frames(7);
    chk("resume_hold", 32'(score), 32'd214);
    frames(1);
    chk("resume_tick", 32'(score), 32'd215);
    frames(14);
    chk("hide_75", 32'(hide), 32'd1);
    frames(124);
    chk("blink_199", 32'(blink), 32'd1);
    gift_req = 1'b1;
    frames(1);
    chk("blink_off", 32'(blink), 32'd0);
    chk("third_ack", 32'(acks), 32'd3);

    // Dead on a tick edge with a pending bonus
    Dead = 1'b1;
    frames(1);
    chk("dead_score", 32'(score), 32'd228);
    chk("dead_run", 32'(run), 32'd0);
    frames(5);
    chk("halt_score", 32'(score), 32'd228);
    chk("halt_noack", 32'(acks), 32'd3);
    chk("hi_228", 32'(hiscore), 32'(hi_exp(228)));

    // Restart from title clears the score
    Dead = 1'b0; gift_req = 1'b0; Game_State = 2'b00;
    frames(2);
    Game_State = 2'b01;
    frames(1);
    chk("restart_zero", 32'(score), 32'd0);
    frames(1200);
    chk("score_120", 32'(score), 32'd120);
    Dead = 1'b1;
    frames(3);
    chk("hi_keep", 32'(hiscore), 32'(hi_exp(228)));
    Dead = 1'b0; Game_State = 2'b00;
    frames(2);
    Game_State = 2'b01;
    frames(1);
    frames(2500);
    chk("score_250", 32'(score), 32'd250);
    Game_State = 2'b10;
    frames(3);
    chk("hi_250", 32'(hiscore), 32'(hi_exp(250)));

    // Asynchronous reset in the middle of a run
    Game_State = 2'b00;
    frames(2);
    Game_State = 2'b01;
    frames(38);
    #3 Reset = 1'b1;
    #1;
    chk("async_score", 32'(score), 32'd0);
    chk("async_run", 32'(run), 32'd0);
    chk("async_hi", 32'(hiscore), 32'd0);
    Game_State = 2'b00;
    frames(2);
    Reset = 1'b0;
    Game_State = 2'b01;
    frames(1);

    // Wrap through SCORE_MAX with a bonus
    frames(9990);
    chk("score_max", 32'(score), 32'(TB_MAX));
    gift_req = 1'b1;
    frames(1);
    chk("wrap_ack", 32'(gift_ack), 32'd1);
    gift_req = 1'b0;
    frames(9);
    chk("wrap_score", 32'(score), 32'd100);
    chk("wrap_blink", 32'(blink), 32'd1);
    chk("wrap_hide", 32'(hide), 32'd0);
    frames(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
